// File: rtl/cim_quantize_seq.sv
// Sequential CIM column quantizer.
// Accepts one row of COLS column sums through a valid/ready handshake, then
// pushes one column per cycle through a shared shift/round/saturate quantizer.
// The shift comes from the active-row count so that a full-scale row sum maps
// onto the OUT_W output range.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready high only in IDLE)
//   cim_input          COLS packed column sums, column c at [c*IN_W +: IN_W]
//   col_en             per-column enable, disabled columns output 0
//   matrix_act         active row count R, legal range 1..2^(ACT_W-1)
//   round_en           1 = round half up, 0 = truncate
//   out_valid/out_ready output handshake (out_valid high only in DONE)
//   q_output           COLS packed quantized columns, column c at [c*OUT_W +: OUT_W]
//   sat_flag           per-column saturation indicator
//   act_err            matrix_act was illegal for this transaction
//   busy               FSM is not in IDLE
module cim_quantize_seq #(
    parameter int unsigned IN_W  = 6,
    parameter int unsigned OUT_W = 4,
    parameter int unsigned COLS  = 8,
    parameter int unsigned ACT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [COLS*IN_W-1:0]    cim_input,
    input  logic [COLS-1:0]         col_en,
    input  logic [ACT_W-1:0]        matrix_act,
    input  logic                    round_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*OUT_W-1:0]   q_output,
    output logic [COLS-1:0]         sat_flag,
    output logic                    act_err,
    output logic                    busy
);

    localparam int unsigned CNT_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned SH_W  = (IN_W - OUT_W > 0) ? $clog2(IN_W - OUT_W + 1) : 1;
    localparam int unsigned MAX_R = 1 << (ACT_W - 1);
    localparam int unsigned EXT_W = IN_W + 1;
    localparam logic [EXT_W-1:0] Q_MAX    = EXT_W'((1 << OUT_W) - 1);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_d;
    logic               out_valid_d;
    logic               busy_d;
    logic               load_c;
    logic               step_c;

    logic [CNT_W-1:0]   cnt_q;
    logic [IN_W-1:0]    col_sum_q [COLS];
    logic [COLS-1:0]    en_q;
    logic [ACT_W-1:0]   act_q;
    logic               rnd_q;

    logic [SH_W-1:0]    shift_c;
    logic [EXT_W-1:0]   ext_c;
    logic [EXT_W-1:0]   t_c;
    logic [OUT_W-1:0]   q_col_c;
    logic               sat_col_c;
    logic               act_bad_c;

    // Legality of the incoming row count, latched into act_err at capture.
    assign act_bad_c = (matrix_act == '0) || (32'(matrix_act) > MAX_R);

    // FSM state and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Next-state logic; registered outputs are decoded from the next state.
    always_comb begin
        state_d     = state_q;
        load_c      = 1'b0;
        step_c      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_c  = 1'b1;
                    state_d = QUANT;
                end
            end
            QUANT: begin
                step_c = 1'b1;
                if (cnt_q == LAST_COL) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Shift = max(0, ceil(log2(R)) - (ACT_W-1) + (IN_W-OUT_W)).
    always_comb begin
        int unsigned k;
        int          sv;
        k = 0;
        for (int unsigned i = 0; i < ACT_W; i++) begin
            if ((32'd1 << i) < 32'(act_q)) begin
                k = i + 1;
            end
        end
        sv      = int'(k) + int'(IN_W - OUT_W) - int'(ACT_W - 1);
        shift_c = (sv > 0) ? SH_W'(sv) : '0;
    end

    // Shared quantizer for the current column; one extra bit absorbs the rounding carry.
    always_comb begin
        ext_c = {1'b0, col_sum_q[cnt_q]};
        if (rnd_q && (shift_c != '0)) begin
            ext_c = ext_c + (EXT_W'(1) << (shift_c - SH_W'(1)));
        end
        t_c       = ext_c >> shift_c;
        q_col_c   = '0;
        sat_col_c = 1'b0;
        if (en_q[cnt_q] && !act_err) begin
            if (t_c > Q_MAX) begin
                q_col_c   = OUT_W'(Q_MAX);
                sat_col_c = 1'b1;
            end else begin
                q_col_c   = OUT_W'(t_c);
            end
        end
    end

    // Capture registers, column counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            en_q     <= '0;
            act_q    <= '0;
            rnd_q    <= 1'b0;
            q_output <= '0;
            sat_flag <= '0;
            act_err  <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                col_sum_q[c] <= '0;
            end
        end else begin
            if (load_c) begin
                cnt_q   <= '0;
                en_q    <= col_en;
                act_q   <= matrix_act;
                rnd_q   <= round_en;
                act_err <= act_bad_c;
                for (int c = 0; c < COLS; c++) begin
                    col_sum_q[c] <= cim_input[c*IN_W +: IN_W];
                end
            end
            if (step_c) begin
                q_output[cnt_q*OUT_W +: OUT_W] <= q_col_c;
                sat_flag[cnt_q]                <= sat_col_c;
                cnt_q <= (cnt_q == LAST_COL) ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cim_quantize_seq.sv
// Self-checking bench for cim_quantize_seq: directed steps from the test plan
// followed by randomized transactions checked against an arithmetic model.
module tb_cim_quantize_seq;

    localparam int IN_W  = 6;
    localparam int OUT_W = 4;
    localparam int COLS  = 8;
    localparam int ACT_W = 5;
    localparam int DW    = COLS * IN_W;
    localparam int QW    = COLS * OUT_W;
    localparam int MAX_R = 1 << (ACT_W - 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     cim_input;
    logic [COLS-1:0]   col_en;
    logic [ACT_W-1:0]  matrix_act;
    logic              round_en;
    logic              out_valid;
    logic              out_ready;
    logic [QW-1:0]     q_output;
    logic [COLS-1:0]   sat_flag;
    logic              act_err;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int last_cap = 0;
    logic [QW-1:0]   last_q;
    logic [COLS-1:0] last_sat;
    logic            last_err;

    cim_quantize_seq #(
        .IN_W(IN_W), .OUT_W(OUT_W), .COLS(COLS), .ACT_W(ACT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .cim_input(cim_input), .col_en(col_en),
        .matrix_act(matrix_act), .round_en(round_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .q_output(q_output), .sat_flag(sat_flag),
        .act_err(act_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: shift from ceil(log2 R), then divide with optional half-up rounding.
    function automatic void ref_model(input logic [DW-1:0] d, input logic [COLS-1:0] en,
                                      input int r, input bit rnd,
                                      output logic [QW-1:0] q, output logic [COLS-1:0] sat,
                                      output logic err);
        int s, v, t;
        q   = '0;
        sat = '0;
        err = (r == 0) || (r > MAX_R);
        s = $clog2(r) - (ACT_W - 1) + (IN_W - OUT_W);
        if (s < 0) s = 0;
        for (int c = 0; c < COLS; c++) begin
            v = int'(d[c*IN_W +: IN_W]);
            if (!err && en[c]) begin
                if (rnd && s > 0) t = (v + 2 ** (s - 1)) / (2 ** s);
                else              t = v / (2 ** s);
                if (t > 2 ** OUT_W - 1) begin
                    q[c*OUT_W +: OUT_W] = OUT_W'(2 ** OUT_W - 1);
                    sat[c] = 1'b1;
                end else begin
                    q[c*OUT_W +: OUT_W] = OUT_W'(t);
                end
            end
        end
    endfunction

    function automatic logic [DW-1:0] pattern(input int a, input int b);
        logic [DW-1:0] d;
        d = '0;
        for (int c = 0; c < COLS; c++) begin
            d[c*IN_W +: IN_W] = (c % 2 == 0) ? IN_W'(a) : IN_W'(b);
        end
        return d;
    endfunction

    // One full transaction, entered and left at a negedge with the DUT in IDLE.
    task automatic do_txn(input logic [DW-1:0] d, input logic [COLS-1:0] en, input int r,
                          input bit rnd, input int hold, input bit chk_space);
        logic [QW-1:0]   eq;
        logic [COLS-1:0] es;
        logic            ee;
        int              n;
        ref_model(d, en, r, rnd, eq, es, ee);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        if (chk_space) check("txn_spacing", 64'(cyc_cnt - last_cap), 64'(COLS + 2));
        last_cap   = cyc_cnt;
        cim_input  = d;
        col_en     = en;
        matrix_act = ACT_W'(r);
        round_en   = rnd;
        in_valid   = 1'b1;
        @(negedge clk);
        check("busy_after_capture", 64'({busy, in_ready, out_valid}), 64'b100);
        // Input changes while busy must not matter.
        cim_input  = DW'({$urandom, $urandom});
        col_en     = COLS'($urandom);
        matrix_act = ACT_W'($urandom);
        round_en   = 1'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("latency", 64'(n), 64'(COLS));
        check("q_output", 64'(q_output), 64'(eq));
        check("sat_flag", 64'(sat_flag), 64'(es));
        check("act_err", 64'(act_err), 64'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_status", 64'({out_valid, in_ready, busy}), 64'b101);
            check("hold_data", 64'({act_err, sat_flag, q_output}), 64'({ee, es, eq}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after_handshake", 64'({out_valid, in_ready, busy}), 64'b010);
        check("post_hold_data", 64'({act_err, sat_flag, q_output}), 64'({ee, es, eq}));
        last_q   = q_output;
        last_sat = sat_flag;
        last_err = act_err;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        cim_input  = '0;
        col_en     = '0;
        matrix_act = '0;
        round_en   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_status", 64'({in_ready, out_valid, busy, act_err}), 64'b1000);
        check("reset_data", 64'({sat_flag, q_output}), 64'd0);

        // Directed plan steps with hand-derived constants.
        do_txn(pattern(63, 63), '1, 16, 1'b0, 0, 1'b0);
        check("all63_r16_q", 64'(last_q), 64'hFFFF_FFFF);
        check("all63_r16_sat", 64'(last_sat), 64'h00);
        do_txn(pattern(63, 63), '1, 8, 1'b0, 0, 1'b1);
        check("all63_r8_sat", 64'({last_sat, last_q}), 64'hFF_FFFF_FFFF);
        do_txn(pattern(63, 63), '1, 1, 1'b0, 0, 1'b1);
        check("all63_r1_sat", 64'({last_sat, last_q}), 64'hFF_FFFF_FFFF);
        do_txn(pattern(42, 21), '1, 16, 1'b0, 0, 1'b1);
        check("alt_trunc", 64'(last_q), 64'h5A5A_5A5A);
        do_txn(pattern(42, 21), '1, 16, 1'b1, 0, 1'b1);
        check("alt_round", 64'(last_q), 64'h5B5B_5B5B);
        do_txn(pattern(42, 21), '1, 8, 1'b1, 0, 1'b1);
        check("alt_r8_round", 64'({last_sat, last_q}), 64'h55_BFBF_BFBF);
        do_txn(pattern(63, 63), '0, 16, 1'b0, 0, 1'b1);
        check("col_en_off", 64'({last_sat, last_q}), 64'd0);
        do_txn(pattern(63, 63), '1, 0, 1'b0, 5, 1'b0);
        check("act_err_r0", 64'({last_err, last_sat, last_q}), 64'h1_00_0000_0000);
        do_txn(pattern(63, 63), '1, 17, 1'b1, 2, 1'b0);
        check("act_err_r17", 64'(last_err), 64'd1);

        // Reset while quantizing column 3 aborts the transaction.
        cim_input  = pattern(63, 63);
        col_en     = '1;
        matrix_act = ACT_W'(16);
        round_en   = 1'b0;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_status", 64'({in_ready, out_valid, busy}), 64'b100);
        check("abort_data", 64'({act_err, sat_flag, q_output}), 64'd0);
        do_txn(pattern(42, 21), 8'hA5, 12, 1'b1, 1, 1'b0);

        // Randomized transactions, including illegal R and random holds.
        for (int i = 0; i < 24; i++) begin
            do_txn(DW'({$urandom, $urandom}), COLS'($urandom), int'($urandom_range(0, 20)),
                   1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
